// File: rtl/argmax_stream_if.sv
// ---------------------------------------------------------------------------
// argmax_stream_if
// Stream bundle for the argmax unit: the score input stream (valid/ready with
// a last marker) and the result output stream (valid/ready with index, max
// value and framing-error flag).
//   master : score producer / result consumer (drives in_*, out_ready)
//   slave  : the argmax unit (drives in_ready, out_*)
// ---------------------------------------------------------------------------
interface argmax_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_WIDTH-1:0]  out_idx;
    logic [DATA_WIDTH-1:0] out_max;
    logic                  out_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_idx, out_max, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_idx, out_max, out_err
    );
endinterface

// File: rtl/argmax_stream.sv
// ---------------------------------------------------------------------------
// argmax_stream
// Sequential argmax over a frame of NUM_CLASSES scores, one score per beat.
// Tracks the running maximum and its index, then presents the winner on the
// result port and holds it until the consumer takes it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   s     : argmax_stream_if.slave (in_valid/in_ready/in_data/in_last,
//           out_valid/out_ready/out_idx/out_max/out_err)
// Parameters: DATA_WIDTH, NUM_CLASSES (>=2), IDX_WIDTH (>=clog2(NUM_CLASSES)),
//             SIGNED (1 = two's-complement compare), TIE_LAST (1 = later
//             index wins on equal scores).
// ---------------------------------------------------------------------------
module argmax_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4,
    parameter int SIGNED      = 0,
    parameter int TIE_LAST    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    argmax_stream_if.slave s
);
    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                state;
    logic [IDX_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] best_val;
    logic [IDX_WIDTH-1:0]  best_idx;

    logic                  accept;
    logic                  last_beat;
    logic                  frame_end;
    logic                  gt;
    logic                  eq;
    logic                  take;
    logic [DATA_WIDTH-1:0] next_val;
    logic [IDX_WIDTH-1:0]  next_idx;

    always_comb begin
        accept    = (state == ACCUM) && s.in_ready && s.in_valid;
        last_beat = (cnt == LAST_IDX);
        frame_end = accept && (s.in_last || last_beat);
        if (SIGNED != 0) begin
            gt = $signed(s.in_data) > $signed(best_val);
        end else begin
            gt = s.in_data > best_val;
        end
        eq = (s.in_data == best_val);
        // The first beat of a frame always seeds the running best.
        take     = (cnt == '0) || gt || ((TIE_LAST != 0) && eq);
        next_val = take ? s.in_data : best_val;
        next_idx = take ? cnt : best_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            cnt         <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            s.in_ready  <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_idx   <= '0;
            s.out_max   <= '0;
            s.out_err   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    s.in_ready <= 1'b1;
                    if (accept) begin
                        best_val <= next_val;
                        best_idx <= next_idx;
                        if (frame_end) begin
                            s.out_idx   <= next_idx;
                            s.out_max   <= next_val;
                            // Short frame or missing last marker; both set err.
                            s.out_err   <= s.in_last ^ last_beat;
                            s.out_valid <= 1'b1;
                            s.in_ready  <= 1'b0;
                            cnt         <= '0;
                            state       <= RESULT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (s.out_valid && s.out_ready) begin
                        s.out_valid <= 1'b0;
                        s.in_ready  <= 1'b1;
                        cnt         <= '0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_argmax_stream.sv
module tb_argmax_stream;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int N  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    argmax_stream_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) ia ();
    argmax_stream_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) ib ();

    // dut_a: unsigned, later index wins ties. dut_b: signed, earlier index kept.
    argmax_stream #(.DATA_WIDTH(DW), .NUM_CLASSES(N), .IDX_WIDTH(IW),
                    .SIGNED(0), .TIE_LAST(1)) dut_a (.clk(clk), .rst_n(rst_n), .s(ia));
    argmax_stream #(.DATA_WIDTH(DW), .NUM_CLASSES(N), .IDX_WIDTH(IW),
                    .SIGNED(1), .TIE_LAST(0)) dut_b (.clk(clk), .rst_n(rst_n), .s(ib));

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
        logic          err;
    } res_t;

    res_t q_a[$];
    res_t q_b[$];
    res_t ea, eb;
    int n_checks = 0;
    int n_fail   = 0;

    // Result monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && ia.out_valid && ia.out_ready) begin
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_result: got idx=%0d max=%h err=%0d, none expected",
                         ia.out_idx, ia.out_max, ia.out_err);
            end else begin
                ea = q_a.pop_front();
                if ({ia.out_idx, ia.out_max, ia.out_err} !== ea) begin
                    n_fail++;
                    $display("FAIL a_result: got idx=%0d max=%h err=%0d, expected idx=%0d max=%h err=%0d",
                             ia.out_idx, ia.out_max, ia.out_err, ea.idx, ea.mx, ea.err);
                end
            end
        end
        if (rst_n && ib.out_valid && ib.out_ready) begin
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_result: got idx=%0d max=%h err=%0d, none expected",
                         ib.out_idx, ib.out_max, ib.out_err);
            end else begin
                eb = q_b.pop_front();
                if ({ib.out_idx, ib.out_max, ib.out_err} !== eb) begin
                    n_fail++;
                    $display("FAIL b_result: got idx=%0d max=%h err=%0d, expected idx=%0d max=%h err=%0d",
                             ib.out_idx, ib.out_max, ib.out_err, eb.idx, eb.mx, eb.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
        ia.in_valid = v; ib.in_valid = v;
        ia.in_data  = d; ib.in_data  = d;
        ia.in_last  = l; ib.in_last  = l;
    endtask

    task automatic set_ready(input logic r);
        ia.out_ready = r; ib.out_ready = r;
    endtask

    task automatic push(input logic [IW-1:0] ia_idx, input logic [DW-1:0] ia_mx, input logic ia_err,
                        input logic [IW-1:0] ib_idx, input logic [DW-1:0] ib_mx, input logic ib_err);
        q_a.push_back('{idx: ia_idx, mx: ia_mx, err: ia_err});
        q_b.push_back('{idx: ib_idx, mx: ib_mx, err: ib_err});
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        drive(1'b1, d, l);
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = ia.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        drive(1'b0, '0, 1'b0);
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL beat_accept_timeout: in_ready=%0d after %0d cycles, required 1", ia.in_ready, t);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d[$], input bit with_last, input bit gaps);
        for (int i = 0; i < d.size(); i++) begin
            if (i == d.size() - 1) begin
                n_checks++;
                if (ia.out_valid !== 1'b0 || ib.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_out_valid: got a=%0d b=%0d, required 0", ia.out_valid, ib.out_valid);
                end
            end
            send_beat(d[i], with_last && (i == d.size() - 1));
            if (gaps && i != d.size() - 1) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (ia.out_valid !== 1'b1 || ib.out_valid !== 1'b1 || ia.in_ready !== 1'b0 || ib.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL result_latency: got out_valid a=%0d b=%0d in_ready a=%0d b=%0d, required 1 1 0 0",
                     ia.out_valid, ib.out_valid, ia.in_ready, ib.in_ready);
        end
    endtask

    task automatic take_result();
        int t;
        t = 0;
        set_ready(1'b1);
        while (ia.out_valid !== 1'b0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        set_ready(1'b0);
        if (t >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL result_handshake_timeout: out_valid=%0d, required 0", ia.out_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b0 || ia.out_idx !== '0 ||
            ia.out_max !== '0 || ia.out_err !== 1'b0 || ib.in_ready !== 1'b0 || ib.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got in_ready=%0d out_valid=%0d idx=%0d max=%h err=%0d, required all 0",
                     ia.in_ready, ia.out_valid, ia.out_idx, ia.out_max, ia.out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1 || ia.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready a=%0d b=%0d out_valid=%0d, required 1 1 0",
                     ia.in_ready, ib.in_ready, ia.out_valid);
        end
    endtask

    task automatic test_nominal();
        logic [DW-1:0] fr[$];
        fr = '{32'd10, 32'd50, 32'd30, 32'd20, 32'd0, 32'd5, 32'd7, 32'd8, 32'd9, 32'd1};
        push(4'd1, 32'd50, 1'b0, 4'd1, 32'd50, 1'b0);
        set_ready(1'b1);   // early out_ready must not matter
        send_frame(fr, 1'b1, 1'b1);
        take_result();
        n_checks++;
        if (ia.out_max !== 32'd50 || ia.out_idx !== 4'd1 || ia.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_after_handshake: got idx=%0d max=%0d in_ready=%0d, required 1 50 1",
                     ia.out_idx, ia.out_max, ia.in_ready);
        end
    endtask

    task automatic test_ties();
        logic [DW-1:0] fr[$];
        fr = '{32'd1, 32'd1, 32'd7, 32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd1, 32'd1};
        push(4'd6, 32'd7, 1'b0, 4'd2, 32'd7, 1'b0);
        send_frame(fr, 1'b1, 1'b0);
        take_result();
        fr = '{32'd20, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd20};
        push(4'd9, 32'd20, 1'b0, 4'd0, 32'd20, 1'b0);
        send_frame(fr, 1'b1, 1'b0);
        take_result();
    endtask

    task automatic test_signed();
        logic [DW-1:0] fr[$];
        fr = '{-32'sd5, -32'sd3, -32'sd9, -32'sd4, -32'sd6, -32'sd7, -32'sd8, -32'sd10, -32'sd11, -32'sd12};
        push(4'd1, 32'hFFFF_FFFD, 1'b0, 4'd1, 32'hFFFF_FFFD, 1'b0);
        send_frame(fr, 1'b1, 1'b1);
        take_result();
        fr = '{32'd3, 32'd1, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd4, 32'd2, 32'd1, 32'd3};
        push(4'd4, 32'hFFFF_FFFF, 1'b0, 4'd3, 32'd5, 1'b0);
        send_frame(fr, 1'b1, 1'b0);
        take_result();
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] fr[$];
        for (int i = 0; i < 4; i++) send_beat(32'd200 + DW'(i), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b0 || ia.out_idx !== '0 || ia.out_max !== '0 ||
            ia.out_err !== 1'b0 || ib.in_ready !== 1'b0 || ib.out_max !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got in_ready=%0d out_valid=%0d idx=%0d max=%h err=%0d, required all 0",
                     ia.in_ready, ia.out_valid, ia.out_idx, ia.out_max, ia.out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fr = '{32'd1, 32'd2, 32'd3, 32'd99, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        push(4'd3, 32'd99, 1'b0, 4'd3, 32'd99, 1'b0);
        send_frame(fr, 1'b1, 1'b0);
        take_result();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] fr[$];
        fr = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd2};
        push(4'd8, 32'd13, 1'b0, 4'd8, 32'd13, 1'b0);
        send_frame(fr, 1'b1, 1'b0);
        drive(1'b1, 32'd1000, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0 || ia.out_idx !== 4'd8 ||
                ia.out_max !== 32'd13 || ib.out_idx !== 4'd8 || ib.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: got valid=%0d in_ready=%0d idx=%0d max=%0d, required 1 0 8 13",
                         c, ia.out_valid, ia.in_ready, ia.out_idx, ia.out_max);
            end
        end
        drive(1'b0, '0, 1'b0);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        set_ready(1'b0);
        n_checks++;
        if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got out_valid=%0d in_ready a=%0d b=%0d, required 0 1 1",
                     ia.out_valid, ia.in_ready, ib.in_ready);
        end
        fr = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        push(4'd0, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0);
        send_frame(fr, 1'b1, 1'b0);
        take_result();
    endtask

    task automatic test_framing();
        logic [DW-1:0] fr[$];
        fr = '{32'd1, 32'd2, 32'd40, 32'd3, 32'd4, 32'd5};
        push(4'd2, 32'd40, 1'b1, 4'd2, 32'd40, 1'b1);
        send_frame(fr, 1'b1, 1'b0);
        take_result();
        fr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd0};
        push(4'd8, 32'd9, 1'b1, 4'd8, 32'd9, 1'b1);
        send_frame(fr, 1'b0, 1'b0);
        take_result();
        fr = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6, 32'd5, 32'd3};
        push(4'd5, 32'd9, 1'b0, 4'd5, 32'd9, 1'b0);
        send_frame(fr, 1'b1, 1'b1);
        take_result();
    endtask

    initial begin
        drive(1'b0, '0, 1'b0);
        set_ready(1'b0);
        test_reset();
        test_nominal();
        test_ties();
        test_signed();
        test_reset_midframe();
        test_backpressure();
        test_framing();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending results, required 0/0", q_a.size(), q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
